// File: rtl/msrv32_machine_ctrl.sv
// Machine-mode trap sequencer: RESET -> OPERATING <-> TRAP_TAKEN / TRAP_RETURN.
// Interrupt sequencing is compiled in only when MSRV32_INTERRUPTS_EN is defined.
module msrv32_machine_ctrl (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       e_irq_in,
  input  logic       s_irq_in,
  input  logic       t_irq_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       msie_in,
  input  logic       mtie_in,
  output logic       flush_out,
  output logic [1:0] pc_src_out,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic       i_or_e_q, i_or_e_d;
  logic       exc, irq, take;
  logic [3:0] irq_cause;

  assign exc = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
               misaligned_store_in | ecall_in | ebreak_in;

`ifdef MSRV32_INTERRUPTS_EN
  assign irq = mie_in & ((e_irq_in & meie_in) | (s_irq_in & msie_in) |
                         (t_irq_in & mtie_in));
  always_comb begin
    irq_cause = 4'd7;
    if (e_irq_in & meie_in)      irq_cause = 4'd11;
    else if (s_irq_in & msie_in) irq_cause = 4'd3;
  end
`else
  logic unused_irq;
  assign unused_irq = ^{e_irq_in, s_irq_in, t_irq_in, mie_in, meie_in, msie_in, mtie_in};
  assign irq        = 1'b0;
  assign irq_cause  = 4'd0;
`endif

  assign take = (state_q == OPERATING) & (exc | irq);

  // Exceptions outrank interrupts; a losing interrupt stays pending at its source.
  always_comb begin
    cause_d  = cause_q;
    i_or_e_d = i_or_e_q;
    if (take) begin
      i_or_e_d = 1'b0;
      if (exc) begin
        if (misaligned_instr_in)      cause_d = 4'd0;
        else if (illegal_instr_in)    cause_d = 4'd2;
        else if (ebreak_in)           cause_d = 4'd3;
        else if (misaligned_load_in)  cause_d = 4'd4;
        else if (misaligned_store_in) cause_d = 4'd6;
        else                          cause_d = 4'd11;
      end else begin
        cause_d  = irq_cause;
        i_or_e_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_out       = 1'b0;
    pc_src_out      = 2'b00;
    trap_taken_out  = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    unique case (state_q)
      RESET: begin
        flush_out = 1'b1;
        state_d   = OPERATING;
      end
      OPERATING: begin
        pc_src_out      = 2'b10;
        instret_inc_out = ~take;
        if (take)         state_d = TRAP_TAKEN;
        else if (mret_in) state_d = TRAP_RETURN;
      end
      TRAP_TAKEN: begin
        flush_out      = 1'b1;
        trap_taken_out = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
        pc_src_out     = 2'b11;
        state_d        = OPERATING;
      end
      TRAP_RETURN: begin
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
        pc_src_out  = 2'b01;
        state_d     = OPERATING;
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= RESET;
      cause_q  <= 4'd0;
      i_or_e_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      i_or_e_q <= i_or_e_d;
    end
  end

  assign cause_out  = cause_q;
  assign i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_msrv32_machine_ctrl.sv
// Randomized scoreboard bench: driver pushes per-cycle expectations from a
// rule-level model, monitor pops and compares on the falling edge.
module tb_msrv32_machine_ctrl;
  logic       clk_in = 1'b0, rst_n_in = 1'b0;
  logic       illegal_instr_in = 0, misaligned_instr_in = 0, misaligned_load_in = 0;
  logic       misaligned_store_in = 0, ecall_in = 0, ebreak_in = 0, mret_in = 0;
  logic       e_irq_in = 0, s_irq_in = 0, t_irq_in = 0;
  logic       mie_in = 0, meie_in = 0, msie_in = 0, mtie_in = 0;
  logic       flush_out, trap_taken_out, set_epc_out, set_cause_out;
  logic [1:0] pc_src_out;
  logic [3:0] cause_out;
  logic       i_or_e_out, mie_clear_out, mie_set_out, instret_inc_out;

  msrv32_machine_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .ecall_in(ecall_in), .ebreak_in(ebreak_in), .mret_in(mret_in),
    .e_irq_in(e_irq_in), .s_irq_in(s_irq_in), .t_irq_in(t_irq_in),
    .mie_in(mie_in), .meie_in(meie_in), .msie_in(msie_in), .mtie_in(mtie_in),
    .flush_out(flush_out), .pc_src_out(pc_src_out), .trap_taken_out(trap_taken_out),
    .set_epc_out(set_epc_out), .set_cause_out(set_cause_out), .cause_out(cause_out),
    .i_or_e_out(i_or_e_out), .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .instret_inc_out(instret_inc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       flush;
    logic [1:0] pc;
    logic       trap, epc, cset, mclr, mset, inst;
    logic [3:0] cause;
    logic       ioe;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Input vector bit positions.
  localparam int MIS_I = 13, ILL = 12, EBRK = 11, MIS_L = 10, MIS_S = 9, ECALL = 8;
  localparam int MRET = 7, EIRQ = 6, SIRQ = 5, TIRQ = 4, MIE = 3, MEIE = 2, MSIE = 1, MTIE = 0;

  // Model: what the sequencer is doing this cycle and the last captured cause.
  typedef enum int {M_BOOT, M_RUN, M_ENTER, M_RETURN} mode_e;
  mode_e    m_mode = M_BOOT;
  int       m_cause = 0;
  bit       m_ioe = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("flush", flush_out, e.flush);
    chk("pc_src", pc_src_out, e.pc);
    chk("trap_taken", trap_taken_out, e.trap);
    chk("set_epc", set_epc_out, e.epc);
    chk("set_cause", set_cause_out, e.cset);
    chk("mie_clear", mie_clear_out, e.mclr);
    chk("mie_set", mie_set_out, e.mset);
    chk("instret", instret_inc_out, e.inst);
    chk("cause", cause_out, e.cause);
    chk("i_or_e", i_or_e_out, e.ioe);
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{flush: 1'b1, pc: 2'b00, trap: 0, epc: 0, cset: 0, mclr: 0, mset: 0,
          inst: 0, cause: 4'd0, ioe: 0};
    return e;
  endfunction

  // Model one cycle: expected outputs for this cycle, then where it goes next.
  task automatic cyc(input logic r, input logic [13:0] v);
    exp_t e;
    int   codes[6] = '{0, 2, 3, 4, 6, 11};
    int   exc_code, irq_code;
    @(posedge clk_in); #1;
    rst_n_in = r;
    {misaligned_instr_in, illegal_instr_in, ebreak_in, misaligned_load_in,
     misaligned_store_in, ecall_in, mret_in, e_irq_in, s_irq_in, t_irq_in,
     mie_in, meie_in, msie_in, mtie_in} = v;
    exc_code = -1;
    for (int i = 0; i < 6; i++)
      if (exc_code < 0 && v[MIS_I - i]) exc_code = codes[i];
    irq_code = -1;
`ifdef MSRV32_INTERRUPTS_EN
    if (v[MIE]) begin
      if (v[EIRQ] && v[MEIE])      irq_code = 11;
      else if (v[SIRQ] && v[MSIE]) irq_code = 3;
      else if (v[TIRQ] && v[MTIE]) irq_code = 7;
    end
`endif
    e = '{flush: 0, pc: 2'b00, trap: 0, epc: 0, cset: 0, mclr: 0, mset: 0,
          inst: 0, cause: 4'(m_cause), ioe: m_ioe};
    if (!r) begin
      e = reset_exp();
      m_mode = M_BOOT; m_cause = 0; m_ioe = 0;
    end else if (m_mode == M_BOOT) begin
      e.flush = 1; m_mode = M_RUN;
    end else if (m_mode == M_ENTER) begin
      e.flush = 1; e.trap = 1; e.epc = 1; e.cset = 1; e.mclr = 1; e.pc = 2'b11;
      m_mode = M_RUN;
    end else if (m_mode == M_RETURN) begin
      e.flush = 1; e.mset = 1; e.pc = 2'b01; m_mode = M_RUN;
    end else begin
      e.pc = 2'b10;
      if (exc_code >= 0) begin
        m_cause = exc_code; m_ioe = 0; m_mode = M_ENTER;
      end else if (irq_code >= 0) begin
        m_cause = irq_code; m_ioe = 1; m_mode = M_ENTER;
      end else begin
        e.inst = 1;
        if (v[MRET]) m_mode = M_RETURN;
      end
    end
    q.push_back(e);
  endtask

  always @(negedge clk_in) begin
    if (q.size() > 0) chk_all(q.pop_front());
  end

  function automatic logic [13:0] rnd_vec();
    logic [13:0] v;
    v = '0;
    for (int i = MIS_S; i <= MIS_I; i++) v[i] = ($urandom_range(0, 19) == 0);
    v[ECALL] = ($urandom_range(0, 19) == 0);
    v[MRET]  = ($urandom_range(0, 5) == 0);
    for (int i = 0; i <= EIRQ; i++) v[i] = ($urandom_range(0, 3) == 0);
    v[MIE]   = $urandom_range(0, 1);
    return v;
  endfunction

  logic [13:0] b;
  initial begin
    #3;
    chk_all(reset_exp());
    cyc(1'b0, '0);
    cyc(1'b1, '0);
    cyc(1'b1, '0);
    // Directed: illegal, timer irq, mie gated, ecall vs external irq, mret.
    b = '0; b[ILL] = 1;                               cyc(1'b1, b);
    cyc(1'b1, '0); cyc(1'b1, '0);
    b = '0; b[TIRQ] = 1; b[MTIE] = 1; b[MIE] = 1;     cyc(1'b1, b);
    cyc(1'b1, '0); cyc(1'b1, '0);
    b = '0; b[TIRQ] = 1; b[MTIE] = 1;                 cyc(1'b1, b);
    b = '0; b[ECALL] = 1; b[EIRQ] = 1; b[MEIE] = 1; b[MIE] = 1; cyc(1'b1, b);
    cyc(1'b1, '0); cyc(1'b1, '0);
    b = '0; b[MRET] = 1;                              cyc(1'b1, b);
    cyc(1'b1, '0); cyc(1'b1, '0);
    b = '0; b[MRET] = 1; b[MIS_S] = 1; b[MIS_L] = 1;  cyc(1'b1, b);
    cyc(1'b1, '0);
    // Async reset while in TRAP_TAKEN.
    b = '0; b[EBRK] = 1;                              cyc(1'b1, b);
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    #1;
    chk_all(reset_exp());
    m_mode = M_BOOT; m_cause = 0; m_ioe = 0;
    cyc(1'b0, '1);
    cyc(1'b1, '0);
    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0, rnd_vec());
    cyc(1'b1, '0);
    repeat (3) @(negedge clk_in);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
